// File: rtl/core_pkg.sv
// Shared types for the core writeback path: the result line format and the shared-source ids.
// Pure declarations plus one helper; no logic, no latency, no flow control.
package core_pkg;

  localparam int WB_NUM_SHARED = 3;
  localparam int RD_W          = 5;
  localparam int XLEN          = 32;

  typedef struct packed {
    logic            ready;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] value;
  } wb_line;

  typedef enum logic [1:0] {
    WB_SRC_BRANCH,
    WB_SRC_LDST,
    WB_SRC_MUL
  } wb_src_t;

  function automatic wb_src_t wb_src_next(wb_src_t s);
    case (s)
      WB_SRC_BRANCH: return WB_SRC_LDST;
      WB_SRC_LDST:   return WB_SRC_MUL;
      default:       return WB_SRC_BRANCH;
    endcase
  endfunction

endpackage

// File: rtl/core_wb_rr_pick.sv
// Rotating-priority pick of up to two shared sources onto the free write ports.
// Purely combinational (0 cycles); a requester left without a port is simply not granted.
module core_wb_rr_pick
  import core_pkg::*;
(
  input  logic    [2:0] req,
  input  wb_src_t       rr_ptr,
  input  logic          free_a,
  input  logic          free_b,
  output logic    [2:0] grant,
  output logic    [2:0] port_of,
  output wb_src_t       next_ptr
);

  // port_of[src] is 0 for port A, 1 for port B; meaningful only where grant[src] is set.
  always_comb begin
    wb_src_t cur;
    logic    a_left;
    logic    b_left;
    grant    = '0;
    port_of  = '0;
    next_ptr = rr_ptr;
    a_left   = free_a;
    b_left   = free_b;
    cur      = rr_ptr;
    for (int k = 0; k < WB_NUM_SHARED; k++) begin
      if (req[cur] && (a_left || b_left)) begin
        grant[cur]   = 1'b1;
        port_of[cur] = !a_left;
        if (a_left) a_left = 1'b0;
        else        b_left = 1'b0;
        next_ptr = wb_src_next(cur);
      end
      cur = wb_src_next(cur);
    end
  end

endmodule

// File: rtl/core_wb_scheduler.sv
// Fair scheduler of ALU lanes and shared units (branch, ldst, mul) onto the two register-file write ports.
// 1-cycle registered latency; losers see wb_stall_*, long stalls raise wb_hold_alu to drain ALU issue.
module core_wb_scheduler
  import core_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  input  wb_line wb_alu_a,
  input  wb_line wb_alu_b,
  input  wb_line wb_branch,
  input  wb_line wb_ldst,
  input  wb_line wb_mul,
  output wb_line wr_a,
  output wb_line wr_b,
  output logic   wb_stall_branch,
  output logic   wb_stall_ldst,
  output logic   wb_stall_mul,
  output logic   wb_hold_alu
);

  localparam int               AGE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  wb_line           src [WB_NUM_SHARED];
  logic [2:0]       req;
  logic [2:0]       grant;
  logic [2:0]       port_of;
  logic             free_a;
  logic             free_b;
  wb_src_t          rr_ptr;
  wb_src_t          next_ptr;
  logic [AGE_W-1:0] age_q [WB_NUM_SHARED];
  logic [AGE_W-1:0] age_d [WB_NUM_SHARED];
  logic             starved;
  wb_line           wr_a_d;
  wb_line           wr_b_d;

  assign src[0] = wb_branch;
  assign src[1] = wb_ldst;
  assign src[2] = wb_mul;
  assign req    = {wb_mul.ready, wb_ldst.ready, wb_branch.ready};

  // Gating the free flags with rst_n suppresses every grant while reset is held.
  assign free_a = rst_n && !wb_alu_a.ready;
  assign free_b = rst_n && !wb_alu_b.ready;

  core_wb_rr_pick u_pick (
    .req      (req),
    .rr_ptr   (rr_ptr),
    .free_a   (free_a),
    .free_b   (free_b),
    .grant    (grant),
    .port_of  (port_of),
    .next_ptr (next_ptr)
  );

  assign wb_stall_branch = req[0] && !grant[0];
  assign wb_stall_ldst   = req[1] && !grant[1];
  assign wb_stall_mul    = req[2] && !grant[2];

  always_comb begin
    wr_a_d  = '0;
    wr_b_d  = '0;
    starved = 1'b0;
    if (wb_alu_a.ready) wr_a_d = wb_alu_a;
    if (wb_alu_b.ready) wr_b_d = wb_alu_b;
    for (int i = 0; i < WB_NUM_SHARED; i++) begin
      if (grant[i]) begin
        if (port_of[i]) wr_b_d = src[i];
        else            wr_a_d = src[i];
      end
      if (grant[i] || !req[i])   age_d[i] = '0;
      else if (age_q[i] == AGE_MAX) age_d[i] = age_q[i];
      else                       age_d[i] = age_q[i] + 1'b1;
      starved = starved || (age_d[i] == AGE_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_a        <= '0;
      wr_b        <= '0;
      rr_ptr      <= WB_SRC_BRANCH;
      wb_hold_alu <= 1'b0;
      for (int i = 0; i < WB_NUM_SHARED; i++) age_q[i] <= '0;
    end else begin
      wr_a        <= wr_a_d;
      wr_b        <= wr_b_d;
      rr_ptr      <= next_ptr;
      wb_hold_alu <= starved;
      for (int i = 0; i < WB_NUM_SHARED; i++) age_q[i] <= age_d[i];
    end
  end

endmodule
